morse_tx_encoder: RTL and testbench

- ASCII-to-Morse transmitter: the encode direction of the Morse decoder IP.
- A Nios II master writes one ASCII character over the Avalon-MM slave port.
- The block looks up the packed Morse code and drives key_out with standard timing: dot = 1 unit, dash = 3, symbol gap = 1, letter gap = 3, word gap = 7.
- The packed code uses the decoder's format, so the two blocks loop back directly.

---
 rtl/morse_tx_encoder.sv | 185 ++++++++++++++++++
 tb/tb_morse_tx_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_encoder.sv
// morse_tx_encoder: Avalon-MM ASCII-to-Morse keyer sharing the decoder's packed {len[7:5], symbols[4:0]} format.
// Define MORSE_TX_FIFO_EN to queue addr0 writes in a 4-entry character FIFO.
module morse_tx_encoder #(
  parameter int DOT_TIME = 25_000_000,
  localparam int CW = $clog2(7*DOT_TIME+1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        key_out,
  output logic        busy,
  output logic [7:0]  packed_out
);
  typedef enum logic [2:0] {IDLE, LOAD, MARK, GAP, LGAP, WGAP} state_t;
  localparam logic [CW-1:0] t_one = CW'(DOT_TIME - 1);
  localparam logic [CW-1:0] t_three = CW'(3*DOT_TIME - 1);
  localparam logic [CW-1:0] t_seven = CW'(7*DOT_TIME - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] code_r, src_char;
  logic [4:0] sh;
  logic [2:0] rem;
  logic done, err, ovr;
  logic wr0, wr1, wr3, src_valid, can_take, start, bad, drop, fin, unused_bits;
  logic [8:0] lut_q;
  logic [31:0] stat3, rdmux;

  // {supported, packed code}; space is supported with length 0 and selects the word gap
  function automatic logic [8:0] lut(input logic [7:0] ch);
    logic [7:0] u;
    u = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
    case (u)
      8'h20: lut = {1'b1, 8'h00};
      "A": lut = {1'b1, 8'h41};
      "B": lut = {1'b1, 8'h88};
      "C": lut = {1'b1, 8'h8a};
      "D": lut = {1'b1, 8'h64};
      "E": lut = {1'b1, 8'h20};
      "F": lut = {1'b1, 8'h82};
      "G": lut = {1'b1, 8'h66};
      "H": lut = {1'b1, 8'h80};
      "I": lut = {1'b1, 8'h40};
      "J": lut = {1'b1, 8'h87};
      "K": lut = {1'b1, 8'h65};
      "L": lut = {1'b1, 8'h84};
      "M": lut = {1'b1, 8'h43};
      "N": lut = {1'b1, 8'h42};
      "O": lut = {1'b1, 8'h67};
      "P": lut = {1'b1, 8'h86};
      "Q": lut = {1'b1, 8'h8d};
      "R": lut = {1'b1, 8'h62};
      "S": lut = {1'b1, 8'h60};
      "T": lut = {1'b1, 8'h21};
      "U": lut = {1'b1, 8'h61};
      "V": lut = {1'b1, 8'h81};
      "W": lut = {1'b1, 8'h63};
      "X": lut = {1'b1, 8'h89};
      "Y": lut = {1'b1, 8'h8b};
      "Z": lut = {1'b1, 8'h8c};
      "0": lut = {1'b1, 8'hbf};
      "1": lut = {1'b1, 8'haf};
      "2": lut = {1'b1, 8'ha7};
      "3": lut = {1'b1, 8'ha3};
      "4": lut = {1'b1, 8'ha1};
      "5": lut = {1'b1, 8'ha0};
      "6": lut = {1'b1, 8'hb0};
      "7": lut = {1'b1, 8'hb8};
      "8": lut = {1'b1, 8'hbc};
      "9": lut = {1'b1, 8'hbe};
      default: lut = 9'h000;
    endcase
  endfunction

  assign wr0 = write && address == 2'd0;
  assign wr1 = write && address == 2'd1;
  assign wr3 = write && address == 2'd3;
  assign fin = (state == LGAP || state == WGAP) && cnt == '0;
  assign unused_bits = ^writedata[31:8];

`ifdef MORSE_TX_FIFO_EN
  logic [7:0] fifo [4];
  logic [1:0] rp, wp;
  logic [2:0] fcnt;
  logic pop, push;
  // an empty FIFO lets a write start straight away, keeping IDLE timing identical to the unqueued build
  assign can_take = state == IDLE || fin;
  assign src_valid = fcnt != 3'd0 || wr0;
  assign src_char = fcnt != 3'd0 ? fifo[rp] : writedata[7:0];
  assign pop = can_take && fcnt != 3'd0;
  assign push = wr0 && !(can_take && fcnt == 3'd0) && fcnt != 3'd4;
  assign drop = wr0 && fcnt == 3'd4;
  assign stat3 = {27'b0, ovr, 1'b0, fcnt};
  always_ff @(posedge clk)
    if (push) fifo[wp] <= writedata[7:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rp <= '0;
      wp <= '0;
      fcnt <= '0;
    end else begin
      rp <= pop ? rp + 2'd1 : rp;
      wp <= push ? wp + 2'd1 : wp;
      fcnt <= fcnt + 3'(push) - 3'(pop);
    end
`else
  assign can_take = state == IDLE;
  assign src_valid = wr0;
  assign src_char = writedata[7:0];
  assign drop = wr0 && state != IDLE;
  assign stat3 = {31'b0, ovr};
`endif

  assign lut_q = lut(src_char);
  assign start = can_take && src_valid && lut_q[8];
  assign bad = can_take && src_valid && !lut_q[8];
  assign key_out = state == MARK;
  assign rdmux = address == 2'd1 ? {29'b0, err, done, busy} :
                 address == 2'd2 ? {24'b0, packed_out} :
                 address == 2'd3 ? stat3 : 32'b0;

  // sh holds the remaining symbols left-aligned so sh[4] is always the next one to key
  always_comb begin
    state_n = state;
    cnt_n = cnt == '0 ? '0 : cnt - CW'(1);
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        cnt_n = CW'(1);
      end
      LOAD: if (cnt == '0) begin
        state_n = code_r[7:5] == 3'd0 ? WGAP : MARK;
        cnt_n = code_r[7:5] == 3'd0 ? t_seven : (sh[4] ? t_three : t_one);
      end
      MARK: if (cnt == '0) begin
        state_n = rem > 3'd1 ? GAP : LGAP;
        cnt_n = rem > 3'd1 ? t_one : t_three;
      end
      GAP: if (cnt == '0) begin
        state_n = MARK;
        cnt_n = sh[4] ? t_three : t_one;
      end
      LGAP, WGAP: if (cnt == '0) begin
        state_n = start ? LOAD : IDLE;
        cnt_n = start ? CW'(1) : '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      code_r <= '0;
      sh <= '0;
      rem <= '0;
      packed_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      ovr <= 1'b0;
      readdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (start) code_r <= lut_q[7:0];
      if (state == LOAD && cnt != '0) begin
        packed_out <= code_r;
        sh <= code_r[4:0] << (3'd5 - code_r[7:5]);
        rem <= code_r[7:5];
      end else if (state == MARK && cnt == '0) begin
        sh <= sh << 1;
        rem <= rem - 3'd1;
      end
      busy <= state == LOAD ? 1'b1 : (state_n == IDLE ? 1'b0 : busy);
      done <= (fin && !start) || (done && !(wr1 && writedata[0]));
      err <= bad || (err && !(wr1 && writedata[1]));
      ovr <= drop || (ovr && !(wr3 && writedata[0]));
      if (read) readdata <= rdmux;
    end
endmodule

// File: tb/tb_morse_tx_encoder.sv
// tb_morse_tx_encoder: table and random characters checked against a dot/dash string model of Morse timing.
module tb_morse_tx_encoder;
  localparam int D = 2;
  logic clk = 1'b0, reset_n = 1'b0, write = 1'b0, read = 1'b0;
  logic [1:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic key_out, busy;
  logic [7:0] packed_out;
  int vectors = 0, miscompares = 0;
  logic [7:0] last_pk;
  bit pk_known;
  logic [63:0] cap_k, cap_b, ek, eb;
  logic [31:0] q;

  morse_tx_encoder #(.DOT_TIME(D)) dut (
    .clk(clk), .reset_n(reset_n), .write(write), .read(read), .address(address),
    .writedata(writedata), .readdata(readdata), .key_out(key_out), .busy(busy),
    .packed_out(packed_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] ch; bit ok; logic [7:0] pk; } vec_t;
  vec_t tbl[10];

  string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                       "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                       "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
                       "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  function automatic string morse_of(logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    if (u == " ") return " ";
    if (u >= "A" && u <= "Z") return codes[u - "A"];
    if (u >= "0" && u <= "9") return codes[26 + u - "0"];
    return "";
  endfunction

  function automatic logic [7:0] pack(string p);
    logic [4:0] v;
    v = '0;
    for (int i = 0; i < p.len(); i++) v = {v[3:0], p[i] == "-"};
    return {3'(p.len()), v};
  endfunction

  // key bit t is the key level sampled just after edge N+t; busy spans the load cycle before the key starts
  task automatic wave(input string p, input int t0, inout logic [63:0] kv, inout logic [63:0] bv);
    int t;
    t = t0;
    if (p.len() == 0) return;
    if (p == " ") t += 7*D;
    else for (int i = 0; i < p.len(); i++) begin
      int dur;
      dur = p[i] == "-" ? 3*D : D;
      for (int j = 0; j < dur; j++) kv[t+j] = 1'b1;
      t += dur + (i < p.len() - 1 ? D : 3*D);
    end
    for (int j = t0 - 1; j < t; j++) bv[j] = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    write = 1'b1;
    address = a;
    writedata = d;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    read = 1'b1;
    address = a;
    @(posedge clk);
    #1;
    read = 1'b0;
    r = readdata;
  endtask

  task automatic capture(input int k0);
    for (int k = k0; k < 64; k++) begin
      cap_k[k] = key_out;
      cap_b[k] = busy;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_char(input logic [7:0] c, input bit ok, input logic [7:0] pk);
    logic [63:0] xk, xb;
    logic [31:0] r;
    xk = '0;
    xb = '0;
    wave(morse_of(c), 2, xk, xb);
    cap_k = '0;
    cap_b = '0;
    wr(2'd0, {24'b0, c});
    capture(0);
    check($sformatf("key wave 0x%h", c), cap_k, xk);
    check($sformatf("busy wave 0x%h", c), cap_b, xb);
    if (ok && c != " ") begin
      last_pk = pk;
      pk_known = 1'b1;
    end else if (ok) pk_known = 1'b0;
    if (pk_known) begin
      rd(2'd2, r);
      check($sformatf("addr2 0x%h", c), r, {24'b0, last_pk});
      check($sformatf("packed_out 0x%h", c), packed_out, last_pk);
    end
    rd(2'd1, r);
    check($sformatf("status 0x%h", c), r, ok ? 32'd2 : 32'd4);
    wr(2'd1, ok ? 32'd1 : 32'd2);
    rd(2'd1, r);
    check($sformatf("status cleared 0x%h", c), r, 32'd0);
  endtask

  initial begin
    tbl = '{'{"E", 1'b1, 8'h20}, '{"W", 1'b1, 8'h63}, '{"k", 1'b1, 8'h65}, '{"#", 1'b0, 8'h00},
            '{" ", 1'b1, 8'h00}, '{"A", 1'b1, 8'h41}, '{"0", 1'b1, 8'hbf}, '{"9", 1'b1, 8'hbe},
            '{"z", 1'b1, 8'h8c}, '{"~", 1'b0, 8'h00}};
    repeat (3) @(posedge clk);
    #1;
    check("reset key_out", key_out, 0);
    check("reset busy", busy, 0);
    check("reset packed_out", packed_out, 0);
    check("reset readdata", readdata, 0);
    reset_n = 1'b1;
    last_pk = 8'h00;
    pk_known = 1'b1;
    rd(2'd1, q);
    check("reset status", q, 0);
    rd(2'd3, q);
    check("reset addr3", q, 0);

    for (int i = 0; i < 10; i++) run_char(tbl[i].ch, tbl[i].ok, tbl[i].pk);

    ek = '0;
    eb = '0;
    wave(".", 2, ek, eb);
`ifdef MORSE_TX_FIFO_EN
    wave("-", 12, ek, eb);
    eb[10] = 1'b1;
`endif
    cap_k = '0;
    cap_b = '0;
    wr(2'd0, "E");
    wr(2'd0, "T");
    cap_k[1] = key_out;
    cap_b[1] = busy;
    read = 1'b1;
    address = 2'd3;
    @(posedge clk);
    #1;
    read = 1'b0;
    check("E+T early addr3", readdata, 32'd1);
    capture(2);
    check("E+T key wave", cap_k, ek);
    check("E+T busy wave", cap_b, eb);
`ifdef MORSE_TX_FIFO_EN
    rd(2'd3, q);
    check("E+T addr3 drained", q, 0);
    last_pk = 8'h21;
`else
    rd(2'd3, q);
    check("E+T ovr", q, 32'd1);
    wr(2'd3, 32'd1);
    rd(2'd3, q);
    check("ovr cleared", q, 0);
    last_pk = 8'h20;
`endif
    check("E+T packed_out", packed_out, last_pk);
    rd(2'd1, q);
    check("E+T done", q, 32'd2);
    wr(2'd1, 32'd1);

    wr(2'd0, "E");
    repeat (9) @(posedge clk);
    #1;
    wr(2'd1, 32'd1);
    rd(2'd1, q);
    check("done set beats clear", q, 32'd2);
    read = 1'b1;
    write = 1'b1;
    address = 2'd1;
    writedata = 32'd1;
    @(posedge clk);
    #1;
    read = 1'b0;
    write = 1'b0;
    check("read during write", readdata, 32'd2);
    rd(2'd1, q);
    check("done after clear", q, 0);
    last_pk = 8'h20;

    repeat (12) begin
      logic [7:0] c;
      string p;
      c = 8'($urandom_range(33, 126));
      p = morse_of(c);
      run_char(c, p.len() != 0, pack(p));
    end

    wr(2'd0, "T");
    repeat (3) @(posedge clk);
    #1;
    check("mid-dash key", key_out, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset key_out", key_out, 0);
    check("async reset busy", busy, 0);
    check("async reset packed_out", packed_out, 0);
    check("async reset readdata", readdata, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(2'd1, q);
    check("post-reset status", q, 0);
    rd(2'd3, q);
    check("post-reset addr3", q, 0);
    check("post-reset key_out", key_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
